// File: rtl/ac97_slot_builder_mc.sv
// AC'97 output-frame assembler: sample FIFO, per-frame slot0..slot12 build,
// and a codec register command channel with read-response capture.
module ac97_slot_builder_mc #(
  parameter int NCH        = 2,
  parameter int SAMPLE_W   = 18,
  parameter int DEPTH      = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                    clk_i,
  input  logic                    RESET,
  input  logic                    frame_strobe,
  input  logic                    codec_ready,
  input  logic                    smp_valid,
  output logic                    smp_ready,
  input  logic [NCH*SAMPLE_W-1:0] smp_data,
  input  logic                    reg_we,
  input  logic                    reg_rd,
  input  logic [6:0]              reg_addr,
  input  logic [15:0]             reg_wdata,
  output logic                    cmd_busy,
  output logic                    rd_valid,
  output logic                    rd_err,
  output logic [15:0]             rd_data,
  input  logic [15:0]             slot0_in,
  input  logic [19:0]             slot1_in,
  input  logic [19:0]             slot2_in,
  output logic [15:0]             slot0_o,
  output logic [239:0]            slots_o,
  output logic [15:0]             underrun_cnt
);

  localparam int WORD_W = NCH * SAMPLE_W;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int TW     = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
  // A mono stream fills both front slots, so two slots are driven when NCH == 1.
  localparam int ACT_CH = (NCH == 1) ? 2 : NCH;
  localparam int          SLOT_OFS [6] = '{40, 60, 100, 120, 140, 160};
  localparam logic [15:0] TAG_MASK [6] = '{16'h1000, 16'h0800, 16'h0200,
                                           16'h0100, 16'h0080, 16'h0040};

  typedef enum logic [1:0] {IDLE, PEND_WR, PEND_RD, WAIT_RD} cmd_state_t;

  function automatic logic [19:0] justify(input logic [SAMPLE_W-1:0] s);
    logic [19:0] r;
    r = '0;
    r[19 -: SAMPLE_W] = s;
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty, push, pop;
  logic [WORD_W-1:0] head_p0;
  logic [19:0]       ch_word [6];

  cmd_state_t    state_q, state_d;
  logic [6:0]    cmd_addr;
  logic [15:0]   cmd_wdata;
  logic [TW-1:0] tmo_q;
  logic          latch_wr, latch_rd, emit, rsp_ok, rsp_to, tmo_clr, tmo_inc;
  logic          rsp_match;

  logic [15:0]   slot0_d;
  logic [239:0]  slots_d;

  logic unused_bits;
  assign unused_bits = ^{slot0_in[12:0], slot1_in[19], slot1_in[11:0], slot2_in[3:0]};

  assign fifo_empty = (fifo_cnt == '0);
  assign smp_ready  = (fifo_cnt != FULL_CNT);
  assign pop        = frame_strobe & codec_ready & ~fifo_empty;
  // A simultaneous pop frees the slot, so a push is taken even while full.
  assign push       = smp_valid & (smp_ready | pop);
  assign head_p0    = mem[rd_ptr];
  assign cmd_busy   = (state_q != IDLE);
  assign rsp_match  = (slot0_in[15:13] == 3'b111) && (slot1_in[18:12] == cmd_addr);

  for (genvar k = 0; k < 6; k++) begin : g_ch
    if (k < NCH) begin : g_used
      assign ch_word[k] = justify(head_p0[k*SAMPLE_W +: SAMPLE_W]);
    end else if (NCH == 1 && k == 1) begin : g_dup
      assign ch_word[k] = justify(head_p0[SAMPLE_W-1:0]);
    end else begin : g_zero
      assign ch_word[k] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !RESET) mem[wr_ptr] <= smp_data;
  end

  always_comb begin
    state_d  = state_q;
    latch_wr = 1'b0;
    latch_rd = 1'b0;
    emit     = 1'b0;
    rsp_ok   = 1'b0;
    rsp_to   = 1'b0;
    tmo_clr  = 1'b0;
    tmo_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (reg_we) begin
          latch_wr = 1'b1;
          state_d  = PEND_WR;
        end else if (reg_rd) begin
          latch_rd = 1'b1;
          state_d  = PEND_RD;
        end
      end
      PEND_WR: begin
        if (frame_strobe && codec_ready) begin
          emit    = 1'b1;
          state_d = IDLE;
        end
      end
      PEND_RD: begin
        if (frame_strobe && codec_ready) begin
          emit    = 1'b1;
          tmo_clr = 1'b1;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (frame_strobe) begin
          if (rsp_match) begin
            rsp_ok  = 1'b1;
            state_d = IDLE;
          end else if (tmo_q == TMO_LAST) begin
            rsp_to  = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (latch_wr) begin
      cmd_addr  <= reg_addr;
      cmd_wdata <= reg_wdata;
    end else if (latch_rd) begin
      cmd_addr  <= reg_addr;
    end
  end

  // Frame assembly, sampled into the output registers at the strobe
  always_comb begin
    slot0_d = '0;
    slots_d = '0;
    if (codec_ready) begin
      slot0_d[15] = 1'b1;
      if (emit) begin
        slot0_d[14]   = 1'b1;
        slot0_d[13]   = (state_q == PEND_WR);
        slots_d[19:0] = {(state_q == PEND_RD), cmd_addr, 12'b0};
        if (state_q == PEND_WR) slots_d[39:20] = {cmd_wdata, 4'b0};
      end
      if (!fifo_empty) begin
        for (int k = 0; k < 6; k++) begin
          if (k < ACT_CH) begin
            slots_d = slots_d | (240'(ch_word[k]) << SLOT_OFS[k]);
            slot0_d = slot0_d | TAG_MASK[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (RESET) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      tmo_q        <= '0;
      slot0_o      <= '0;
      slots_o      <= '0;
      rd_valid     <= 1'b0;
      rd_err       <= 1'b0;
      rd_data      <= '0;
      underrun_cnt <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= rsp_ok | rsp_to;
      rd_err   <= rsp_to;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (tmo_clr)      tmo_q <= '0;
      else if (tmo_inc) tmo_q <= tmo_q + 1'b1;
      if (rsp_ok)      rd_data <= slot2_in[19:4];
      else if (rsp_to) rd_data <= '0;
      if (frame_strobe) begin
        slot0_o <= slot0_d;
        slots_o <= slots_d;
        if (codec_ready && fifo_empty) underrun_cnt <= sat_inc(underrun_cnt);
      end
    end
  end

endmodule

// File: doc/ac97_slot_builder_mc.md
Name: ac97_slot_builder_mc

Overview:
Parametrised multi-channel AC'97 output-frame assembler with codec-register command channel.
- Buffers interleaved PCM sample words in a FIFO. On each frame strobe it builds slot0..slot12 for the serial AC'97 link controller.
- Each frame can carry a pending codec register write or read command alongside audio. It captures read responses from the incoming slots.
- Sits between the audio source or bus interface and the AC'97 serial link controller. Successor to the fixed stereo, command-steals-frame AC'97 front end.

Parameters:
NCH, 2, number of playback channels, 1..6; ch0..ch5 map to slots 3,4,6,7,8,9
SAMPLE_W, 18, bits per channel sample, 1..20, left-justified in 20-bit slot with zero LSBs
DEPTH, 8, sample FIFO depth in words, power of two, >=2
RD_TIMEOUT, 4, frame strobes to wait for a read response before aborting

Ports:
clk_i  in  1  system clock
RESET  in  1  synchronous, active-high reset
frame_strobe  in  1  one-cycle pulse per 48 kHz frame (SYNC rising edge, clk_i domain)
codec_ready  in  1  codec ready indication (incoming slot0[15] seen)
smp_valid  in  1  sample word valid
smp_ready  out  1  FIFO can accept a word (= !full)
smp_data  in  NCH*SAMPLE_W  interleaved sample word; ch0 in LSBs
reg_we  in  1  request codec register write
reg_rd  in  1  request codec register read
reg_addr  in  7  codec register address
reg_wdata  in  16  write data
cmd_busy  out  1  command pending or outstanding
rd_valid  out  1  one-cycle pulse: read finished
rd_err  out  1  qualifies rd_valid: timeout, rd_data = 0
rd_data  out  16  read response data
slot0_in  in  16  incoming slot0
slot1_in  in  20  incoming slot1
slot2_in  in  20  incoming slot2
slot0_o  out  16  outgoing tag slot
slots_o  out  240  outgoing slots 1..12; slot n occupies bits [20n-1:20(n-1)]
underrun_cnt  out  16  saturating count of frames with empty FIFO while codec_ready

Behaviour:
Reset:
- Reset has priority over all other inputs.
- slot0_o = 0, slots_o = 0, FIFO emptied, cmd_busy = 0, rd_valid = 0, rd_err = 0, rd_data = 0, underrun_cnt = 0.
- smp_ready = 1 on the first cycle after reset.

FIFO:
- Push on smp_valid & smp_ready. Pop only at a frame_strobe with codec_ready & !empty.
- Push and pop in the same cycle are both honoured, including when full; smp_ready stays 0 that cycle.
- Pointers wrap modulo DEPTH. A separate count distinguishes full from empty.

Command state machine (IDLE, PEND_WR, PEND_RD, WAIT_RD):
- IDLE:
  - reg_we latches addr/data, goes to PEND_WR.
  - else reg_rd latches addr, goes to PEND_RD.
  - Simultaneous reg_we & reg_rd: write wins, read is dropped.
- cmd_busy = (state != IDLE). reg_we and reg_rd are ignored while busy.
- PEND_WR: at the next frame_strobe with codec_ready, emit the write; go to IDLE. cmd_busy falls the cycle after that strobe.
- PEND_RD: at the next frame_strobe with codec_ready, emit the read; go to WAIT_RD; clear the timeout counter.
- WAIT_RD: evaluated on each frame_strobe.
  - If slot0_in[15:13] == 3'b111 and slot1_in[18:12] == latched addr: rd_data <= slot2_in[19:4], rd_valid pulse, rd_err = 0, go to IDLE.
  - Otherwise increment the counter. On reaching RD_TIMEOUT: rd_valid & rd_err pulse, rd_data = 0, go to IDLE.
  - A strobe that emits the read never also matches its own response.

Frame build:
- Registered, updates only in the cycle after frame_strobe. Outputs hold between strobes.
- codec_ready = 0 at strobe:
  - All slots 0, including slot0[15].
  - No FIFO pop, no underrun count; pending command retained.
- codec_ready = 1, slot0 tags:
  - slot0[15] = 1 (valid frame).
  - slot0[14] = 1 if a command is emitted.
  - slot0[13] = 1 if it is a write.
  - Audio tags: slot3 = bit12, slot4 = bit11, slot6 = bit9, slot7 = bit8, slot8 = bit7, slot9 = bit6; set for each active slot when a sample is popped.
  - slot0[12:0] other bits = 0.
- Command slots:
  - slot1 = {rd, addr[6:0], 12'b0}. slot2 = {wdata, 4'b0} for a write, 0 for a read.
  - With no command, slot1 = slot2 = 0.
  - Audio is sent in the same frame as a command.
- Audio slots:
  - Channel k goes to its mapped slot as {sample, (20-SAMPLE_W) zeros}.
  - NCH == 1: ch0 is duplicated into slots 3 and 4, both tagged.
  - Unused slots (5, 10, 11, 12, unmapped channels) = 0.
- FIFO empty at strobe with codec_ready: audio slots 0, audio tags 0, underrun_cnt += 1, saturating at 16'hFFFF. Any command is still emitted.

Test Plan:
- Reset, then NCH=2, SAMPLE_W=18: push 0x12345/0x2ABCD, strobe with codec_ready -> slot0_o = 0x9800, slot3 = 0x48D14, slot4 = 0xAAF34, FIFO empty.
- Strobe with codec_ready=0 while FIFO holds 3 words and a write is pending -> all slots 0; FIFO count stays 3; cmd_busy stays 1.
- reg_we addr 0x02 data 0x8000 plus 1 queued sample, then strobe -> slot0_o = 0xF800, slot1 = 0x02000, slot2 = 0x80000; cmd_busy falls the cycle after the strobe.
- Read addr 0x26; response slot0_in = 0xE000, slot1_in = 0x26000, slot2_in = 0x000F0 on the second strobe -> rd_valid pulse, rd_data = 0x000F, rd_err = 0. Repeat with no response -> rd_err pulse after 4 strobes.
- Fill FIFO to DEPTH=8 (smp_ready = 0), push and pop in the same cycle, then drain and strobe 3 more times -> underrun_cnt = 3, audio tags 0.
- NCH=1: push 0x3FFFF, strobe -> slot3 = slot4 = 0xFFFFC, slot0_o = 0x9800. Simultaneous reg_we & reg_rd -> only the write is emitted.
